// File: rtl/pa_cpu.sv
// Shared definitions for the CPU interrupt path: IRQ count, spurious vector
// and the handshake state encoding used by interrupt_controller.
package pa_cpu;

    localparam int NUM_IRQ = 8;
    localparam logic [7:0] SPURIOUS_VECTOR = 8'hFE;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_HOLD = 2'd2
    } e_int_ctrl_state;

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line synchroniser for an asynchronous IRQ input, followed by a delay
// flop and a registered rising-edge pulse.
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;
    logic                   rise_r;

    // Metastability chain, delay flop and one-cycle rise pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_r   <= '0;
            sync_d_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], d};
            sync_d_r <= sync_r[SYNC_STAGES-1];
            rise_r   <= sync_r[SYNC_STAGES-1] & ~sync_d_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/interrupt_controller.sv
// Latches synchronised IRQ edges as pending bits, masks them, and runs the
// request/acknowledge handshake with the microcode sequencer.
module interrupt_controller
    import pa_cpu::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic [7:0]           z_bus,
    input  logic                 status_irq_en,
    input  logic                 ctrl_irq_masks_wrt,
    input  logic                 ctrl_int_ack,
    input  logic                 ctrl_clear_all_ints,
    output logic                 int_pending,
    output logic [7:0]           int_vector,
    output logic [7:0]           irq_masks,
    output logic [7:0]           irq_pending_flags
);

    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] active_s;
    logic [NUM_IRQ-1:0] ack_clr_s;
    logic [NUM_IRQ-1:0] pending_nxt_s;
    logic [NUM_IRQ-1:0] pending_r;
    logic [7:0]         masks_r;
    logic               ack_d_r;
    logic               ack_rise_s;
    logic               retire_s;
    logic [2:0]         win_idx_s;
    logic [7:0]         win_vector_s;
    e_int_ctrl_state    state_r;
    logic               int_pending_r;
    logic [7:0]         int_vector_r;

    // Lowest set index wins, so IRQ0 has the highest priority
    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .arst_n (arst_n),
            .d      (irq_in[g]),
            .rise   (rise_s[g])
        );
    end

    // Winner selection, ack edge detection and the retire decision
    always_comb begin
        active_s     = pending_r & masks_r;
        ack_rise_s   = ctrl_int_ack & ~ack_d_r;
        win_idx_s    = lowest_idx(active_s);
        win_vector_s = {4'b0000, win_idx_s, 1'b0};
        retire_s     = (state_r == IC_REQ) && ack_rise_s && (|active_s);
        if (retire_s) begin
            ack_clr_s = 8'd1 << win_idx_s;
        end else begin
            ack_clr_s = 8'd0;
        end
    end

    // Per-bit pending update: clear_all, then new edge, then ack retire
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ctrl_clear_all_ints) begin
                pending_nxt_s[i] = 1'b0;
            end else if (rise_s[i]) begin
                pending_nxt_s[i] = 1'b1;
            end else if (ack_clr_s[i]) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Pending latches, mask register and ack edge history
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_r <= '0;
            masks_r   <= 8'h00;
            ack_d_r   <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            ack_d_r   <= ctrl_int_ack;
            if (ctrl_irq_masks_wrt) begin
                masks_r <= z_bus;
            end else begin
                masks_r <= masks_r;
            end
        end
    end

    // Handshake FSM with registered request and captured vector
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r       <= IC_IDLE;
            int_pending_r <= 1'b0;
            int_vector_r  <= 8'h00;
        end else begin
            if (ack_rise_s) begin
                int_vector_r <= retire_s ? win_vector_s : SPURIOUS_VECTOR;
            end else begin
                int_vector_r <= int_vector_r;
            end
            case (state_r)
                IC_IDLE: begin
                    if ((|active_s) && status_irq_en) begin
                        state_r       <= IC_REQ;
                        int_pending_r <= 1'b1;
                    end else begin
                        int_pending_r <= 1'b0;
                    end
                end
                IC_REQ: begin
                    if (retire_s) begin
                        state_r       <= IC_HOLD;
                        int_pending_r <= 1'b0;
                    end else if (!(|active_s) || !status_irq_en) begin
                        state_r       <= IC_IDLE;
                        int_pending_r <= 1'b0;
                    end else begin
                        int_pending_r <= 1'b1;
                    end
                end
                IC_HOLD: begin
                    state_r       <= IC_IDLE;
                    int_pending_r <= 1'b0;
                end
                default: begin
                    state_r       <= IC_IDLE;
                    int_pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign int_pending       = int_pending_r;
    assign int_vector        = int_vector_r;
    assign irq_masks         = masks_r;
    assign irq_pending_flags = pending_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: table-driven vectors plus
// hand-written handshake sequences, checked through an expectation queue.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] irq_in;
    logic [7:0] z_bus;
    logic       status_irq_en;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_pending_flags;

    always #5 clk = ~clk;

    interrupt_controller #(.SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .irq_in              (irq_in),
        .z_bus               (z_bus),
        .status_irq_en       (status_irq_en),
        .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
        .ctrl_int_ack        (ctrl_int_ack),
        .ctrl_clear_all_ints (ctrl_clear_all_ints),
        .int_pending         (int_pending),
        .int_vector          (int_vector),
        .irq_masks           (irq_masks),
        .irq_pending_flags   (irq_pending_flags)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] mask;
        logic       en;
        logic [7:0] exp_flags;
        logic       exp_ip;
        logic [7:0] exp_vec;
        logic [7:0] exp_after;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_val(input string name, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_next(input logic [7:0] act);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_mask(input logic [7:0] m);
        z_bus = m;
        ctrl_irq_masks_wrt = 1'b1;
        cyc(1);
        ctrl_irq_masks_wrt = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irq_in = bits;
        cyc(1);
        irq_in = 8'h00;
    endtask

    task automatic pulse_ack();
        ctrl_int_ack = 1'b1;
        cyc(1);
        ctrl_int_ack = 1'b0;
    endtask

    task automatic clear_all();
        ctrl_clear_all_ints = 1'b1;
        cyc(1);
        ctrl_clear_all_ints = 1'b0;
        cyc(2);
    endtask

    task automatic wait_ip(input string name, input int max_cyc);
        logic ok;
        ok = 1'b0;
        expect_val(name, 8'h01);
        for (int i = 0; i < max_cyc; i++) begin
            if (int_pending === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        check_next({7'd0, ok});
    endtask

    initial begin
        tbl[0] = '{8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 8'h00, 8'h00};
        tbl[1] = '{8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 8'h0E, 8'h00};
        tbl[2] = '{8'h18, 8'hFF, 1'b1, 8'h18, 1'b1, 8'h06, 8'h10};
        tbl[3] = '{8'h18, 8'hF0, 1'b1, 8'h18, 1'b1, 8'h08, 8'h08};
        tbl[4] = '{8'h40, 8'hBF, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40};
        tbl[5] = '{8'h20, 8'hFF, 1'b0, 8'h20, 1'b0, 8'h00, 8'h20};
        tbl[6] = '{8'h24, 8'hDF, 1'b1, 8'h24, 1'b1, 8'h04, 8'h20};

        arst_n = 1'b0;
        irq_in = 8'h00;
        z_bus = 8'h00;
        status_irq_en = 1'b0;
        ctrl_irq_masks_wrt = 1'b0;
        ctrl_int_ack = 1'b0;
        ctrl_clear_all_ints = 1'b0;
        cyc(2);
        expect_val("rst_int_pending", 8'h00); check_next({7'd0, int_pending});
        expect_val("rst_int_vector", 8'h00);  check_next(int_vector);
        expect_val("rst_masks", 8'h00);       check_next(irq_masks);
        expect_val("rst_flags", 8'h00);       check_next(irq_pending_flags);
        arst_n = 1'b1;
        cyc(2);

        // Single IRQ5: exact latency, then acknowledge
        write_mask(8'hFF);
        status_irq_en = 1'b1;
        expect_val("lat_flags_p2", 8'h00);
        expect_val("lat_flags_p3", 8'h20);
        expect_val("lat_ip_p3", 8'h00);
        expect_val("lat_ip_p4", 8'h01);
        pulse_irq(8'h20);
        cyc(2);
        check_next(irq_pending_flags);
        cyc(1);
        check_next(irq_pending_flags);
        check_next({7'd0, int_pending});
        cyc(1);
        check_next({7'd0, int_pending});
        expect_val("ack5_vector", 8'h0A);
        expect_val("ack5_flags", 8'h00);
        expect_val("ack5_ip", 8'h00);
        pulse_ack();
        check_next(int_vector);
        check_next(irq_pending_flags);
        check_next({7'd0, int_pending});
        cyc(3);
        expect_val("ack5_ip_quiet", 8'h00); check_next({7'd0, int_pending});

        // IRQ6 and IRQ2 together: two acks in priority order
        pulse_irq(8'h44);
        wait_ip("two_req1", 12);
        expect_val("two_vec1", 8'h04);
        expect_val("two_flags1", 8'h40);
        expect_val("two_hold_ip", 8'h00);
        pulse_ack();
        check_next(int_vector);
        check_next(irq_pending_flags);
        check_next({7'd0, int_pending});
        wait_ip("two_req2", 6);
        expect_val("two_vec2", 8'h0C);
        expect_val("two_flags2", 8'h00);
        pulse_ack();
        check_next(int_vector);
        check_next(irq_pending_flags);
        cyc(2);

        // Masked IRQ3 stays pending, fires once unmasked
        write_mask(8'h00);
        pulse_irq(8'h08);
        cyc(5);
        expect_val("mask_flags", 8'h08); check_next(irq_pending_flags);
        expect_val("mask_ip", 8'h00);    check_next({7'd0, int_pending});
        expect_val("unmask_ip_p1", 8'h00);
        expect_val("unmask_ip_p2", 8'h01);
        write_mask(8'h08);
        check_next({7'd0, int_pending});
        cyc(1);
        check_next({7'd0, int_pending});
        clear_all();

        // Held ack retires only one interrupt
        write_mask(8'hFF);
        pulse_irq(8'h03);
        wait_ip("held_req", 12);
        expect_val("held_vec", 8'h00);
        expect_val("held_flags", 8'h02);
        ctrl_int_ack = 1'b1;
        cyc(4);
        ctrl_int_ack = 1'b0;
        check_next(int_vector);
        check_next(irq_pending_flags);
        clear_all();

        // Spurious ack, then clear_all racing an IRQ1 edge
        expect_val("spur_vec", 8'hFE);
        expect_val("spur_flags", 8'h00);
        expect_val("spur_ip", 8'h00);
        pulse_ack();
        check_next(int_vector);
        check_next(irq_pending_flags);
        check_next({7'd0, int_pending});
        pulse_irq(8'h02);
        cyc(2);
        ctrl_clear_all_ints = 1'b1;
        cyc(1);
        ctrl_clear_all_ints = 1'b0;
        expect_val("clr_race_flags", 8'h00); check_next(irq_pending_flags);
        cyc(3);
        expect_val("clr_race_flags_late", 8'h00); check_next(irq_pending_flags);
        expect_val("clr_race_ip", 8'h00);         check_next({7'd0, int_pending});

        // Async reset while requesting
        pulse_irq(8'h80);
        wait_ip("rst_mid_req", 12);
        expect_val("rst_mid_ip", 8'h00);
        expect_val("rst_mid_vec", 8'h00);
        expect_val("rst_mid_masks", 8'h00);
        expect_val("rst_mid_flags", 8'h00);
        #1;
        arst_n = 1'b0;
        #1;
        check_next({7'd0, int_pending});
        check_next(int_vector);
        check_next(irq_masks);
        check_next(irq_pending_flags);
        cyc(2);
        arst_n = 1'b1;
        cyc(2);

        for (int t = 0; t < 7; t++) begin
            ctrl_clear_all_ints = 1'b1;
            cyc(1);
            ctrl_clear_all_ints = 1'b0;
            write_mask(tbl[t].mask);
            status_irq_en = tbl[t].en;
            cyc(2);
            expect_val($sformatf("tbl%0d_flags", t), tbl[t].exp_flags);
            expect_val($sformatf("tbl%0d_ip", t), {7'd0, tbl[t].exp_ip});
            pulse_irq(tbl[t].irq);
            cyc(5);
            check_next(irq_pending_flags);
            check_next({7'd0, int_pending});
            if (tbl[t].exp_ip) begin
                expect_val($sformatf("tbl%0d_vec", t), tbl[t].exp_vec);
                expect_val($sformatf("tbl%0d_after", t), tbl[t].exp_after);
                pulse_ack();
                check_next(int_vector);
                check_next(irq_pending_flags);
            end
            cyc(2);
        end

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
